bl_scan_sequencer: RTL and testbench

//  Clocked sequencer that sweeps bit-line columns 0..NUM_BL-1 and drives the enable/address

---
 rtl/bl_scan_sequencer_if.sv | 33 +++
 rtl/bl_scan_sequencer.sv | 179 +++++++++++++++++
 tb/tb_bl_scan_sequencer.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/bl_scan_sequencer_if.sv
// Control/status bundle between a scan controller and bl_scan_sequencer.
// col_mask exists only when BL_SCAN_MASK_EN is defined.
interface bl_scan_sequencer_if #(
    parameter int ADDR_W  = 3,
    parameter int DWELL_W = 8
);
    localparam int NUM_BL = 2 ** ADDR_W;

    logic               start;
    logic               stop;
    logic               continuous;
    logic [DWELL_W-1:0] dwell;
`ifdef BL_SCAN_MASK_EN
    logic [NUM_BL-1:0]  col_mask;
`endif
    logic               en;
    logic [ADDR_W-1:0]  addr;
    logic               sample;
    logic               busy;
    logic               done;

`ifdef BL_SCAN_MASK_EN
    modport master (output start, stop, continuous, dwell, col_mask,
                    input  en, addr, sample, busy, done);
    modport slave  (input  start, stop, continuous, dwell, col_mask,
                    output en, addr, sample, busy, done);
`else
    modport master (output start, stop, continuous, dwell,
                    input  en, addr, sample, busy, done);
    modport slave  (input  start, stop, continuous, dwell,
                    output en, addr, sample, busy, done);
`endif
endinterface

// File: rtl/bl_scan_sequencer.sv
// Bit-line column scan sequencer driving the downstream mux EN/address inputs.
// Optional column masking is enabled by defining BL_SCAN_MASK_EN.
module bl_scan_sequencer #(
    parameter int ADDR_W  = 3,
    parameter int DWELL_W = 8,
    parameter int SETTLE  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    bl_scan_sequencer_if.slave   bus
);
    localparam int unsigned NUM_BL = 2 ** ADDR_W;
    localparam int          SET_W  = $clog2(SETTLE + 1);
    localparam int          CNT_W  = (DWELL_W > SET_W) ? DWELL_W : SET_W;
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_DWELL,
        S_GAP,
        S_DONE
    } state_t;

    state_t              state, state_n;
    logic [CNT_W-1:0]    cnt, cnt_n;
    logic [ADDR_W-1:0]   col, col_n;
    logic [DWELL_W-1:0]  d_lat, d_n;
    logic                cont_lat, cont_n;
    logic [NUM_BL-1:0]   mask_lat, mask_n;
    logic [NUM_BL-1:0]   mask_in;
    logic [CNT_W-1:0]    dwell_last;

    logic                en_q, en_n;
    logic [ADDR_W-1:0]   addr_q, addr_n;
    logic                sample_q, sample_n;
    logic                busy_q, busy_n;
    logic                done_q, done_n;

    logic                nxt_found;
    logic [ADDR_W-1:0]   nxt_col;

`ifdef BL_SCAN_MASK_EN
    assign mask_in = bus.col_mask;
`else
    assign mask_in = '1;
`endif

    assign dwell_last = CNT_W'(d_lat) - CNT_W'(1);

    function automatic logic [ADDR_W-1:0] first_col(input logic [NUM_BL-1:0] m);
        first_col = '0;
        for (int unsigned i = NUM_BL; i > 0; i--) begin
            if (m[i-1]) first_col = ADDR_W'(i - 1);
        end
    endfunction

    // Next scanned column above the current one, searched in the latched mask.
    always_comb begin
        nxt_found = 1'b0;
        nxt_col   = '0;
        for (int unsigned i = NUM_BL; i > 0; i--) begin
            if (mask_lat[i-1] && ((i - 1) > 32'(col))) begin
                nxt_found = 1'b1;
                nxt_col   = ADDR_W'(i - 1);
            end
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        col_n   = col;
        d_n     = d_lat;
        cont_n  = cont_lat;
        mask_n  = mask_lat;

        case (state)
            S_IDLE: begin
                if (bus.start && !bus.stop) begin
                    d_n     = (bus.dwell == '0) ? DWELL_W'(1) : bus.dwell;
                    cont_n  = bus.continuous;
                    mask_n  = mask_in;
                    cnt_n   = '0;
                    col_n   = first_col(mask_in);
                    state_n = (|mask_in) ? S_SETTLE : S_DONE;
                end
            end
            S_SETTLE: begin
                if (cnt == SETTLE_LAST) begin
                    state_n = S_DWELL;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            S_DWELL: begin
                if (cnt == dwell_last) begin
                    cnt_n = '0;
                    if (nxt_found) begin
                        state_n = S_GAP;
                        col_n   = nxt_col;
                    end else begin
                        state_n = S_DONE;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            S_GAP: begin
                state_n = S_SETTLE;
                cnt_n   = '0;
            end
            S_DONE: begin
                // An empty mask never restarts, even in continuous mode.
                if (cont_lat && (|mask_lat)) begin
                    state_n = S_SETTLE;
                    cnt_n   = '0;
                    col_n   = first_col(mask_lat);
                end else begin
                    state_n = S_IDLE;
                    col_n   = '0;
                end
            end
            default: begin
                state_n = S_IDLE;
                cnt_n   = '0;
                col_n   = '0;
            end
        endcase

        if (bus.stop && (state != S_IDLE)) begin
            state_n = S_IDLE;
            cnt_n   = '0;
            col_n   = '0;
        end

        // Outputs are registered copies of what the next state implies.
        en_n     = (state_n == S_SETTLE) || (state_n == S_DWELL);
        addr_n   = ((state_n == S_IDLE) || (state_n == S_DONE)) ? '0 : col_n;
        sample_n = (state_n == S_DWELL) && (cnt_n == dwell_last);
        busy_n   = (state_n != S_IDLE);
        done_n   = (state_n == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
            col      <= '0;
            d_lat    <= DWELL_W'(1);
            cont_lat <= 1'b0;
            mask_lat <= '0;
            en_q     <= 1'b0;
            addr_q   <= '0;
            sample_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            col      <= col_n;
            d_lat    <= d_n;
            cont_lat <= cont_n;
            mask_lat <= mask_n;
            en_q     <= en_n;
            addr_q   <= addr_n;
            sample_q <= sample_n;
            busy_q   <= busy_n;
            done_q   <= done_n;
        end
    end

    assign bus.en     = en_q;
    assign bus.addr   = addr_q;
    assign bus.sample = sample_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
endmodule

// File: tb/tb_bl_scan_sequencer.sv
// Self-checking bench for bl_scan_sequencer: per-cycle expected outputs queued at Start.
// Masked-column cases run only when BL_SCAN_MASK_EN is defined.
module tb_bl_scan_sequencer;
    localparam int SETTLE = 2;

    typedef struct packed {
        logic       en;
        logic [2:0] addr;
        logic       sample;
        logic       busy;
        logic       done;
    } obs_t;

    typedef struct {
        logic [7:0] dwell;
        bit         poke;
        int         exp_done;
        int         exp_en;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   cyc, done_at, en_count;
    obs_t sb[$];

    bl_scan_sequencer_if #(.ADDR_W(3), .DWELL_W(8)) bus ();

    bl_scan_sequencer #(.ADDR_W(3), .DWELL_W(8), .SETTLE(SETTLE)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic obs_t mk(input logic en, input int a, input logic s,
                                input logic b, input logic d);
        obs_t o;
        o.en = en; o.addr = 3'(a); o.sample = s; o.busy = b; o.done = d;
        return o;
    endfunction

    function automatic obs_t observe();
        return {bus.en, bus.addr, bus.sample, bus.busy, bus.done};
    endfunction

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_obs(input string name, input obs_t act, input obs_t exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s @cycle %0d: got en/addr/smp/busy/done=%b/%0d/%b/%b/%b expected %b/%0d/%b/%b/%b",
                     name, cyc, act.en, act.addr, act.sample, act.busy, act.done,
                     exp.en, exp.addr, exp.sample, exp.busy, exp.done);
        end
    endtask

    // Expected trace of one sweep starting the cycle after the Start edge.
    task automatic build_expect(input int dwell, input logic [7:0] m, input bit with_idle);
        int d;
        int cols[$];
        d = (dwell == 0) ? 1 : dwell;
        for (int c = 0; c < 8; c++) if (m[c]) cols.push_back(c);
        foreach (cols[i]) begin
            for (int k = 0; k < SETTLE + d; k++)
                sb.push_back(mk(1'b1, cols[i], (k == SETTLE + d - 1), 1'b1, 1'b0));
            if (i + 1 < cols.size()) sb.push_back(mk(1'b0, cols[i+1], 1'b0, 1'b1, 1'b0));
        end
        sb.push_back(mk(1'b0, 0, 1'b0, 1'b1, 1'b1));
        if (with_idle) sb.push_back(mk(1'b0, 0, 1'b0, 1'b0, 1'b0));
    endtask

    task automatic kick(input logic [7:0] d, input logic cont, input logic [7:0] m);
        @(negedge clk);
        bus.dwell = d;
        bus.continuous = cont;
`ifdef BL_SCAN_MASK_EN
        bus.col_mask = m;
`else
        if (m != 8'hFF) $display("note: mask ignored in this build");
`endif
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.dwell = 8'hAA;
        bus.continuous = ~cont;
`ifdef BL_SCAN_MASK_EN
        bus.col_mask = ~m;
`endif
        cyc = 0;
        done_at = -1;
        en_count = 0;
    endtask

    task automatic run_queue(input int n);
        obs_t act, exp;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cyc++;
            act = observe();
            if (bus.en) en_count++;
            if (bus.done && done_at < 0) done_at = cyc;
            if (sb.size() == 0) begin
                check_obs("sb_underflow", act, '0);
            end else begin
                exp = sb.pop_front();
                if (exp.done) act.addr = exp.addr;
                check_obs("cycle", act, exp);
            end
        end
    endtask

    // Address must never move while EN is high on both sides of the change.
    logic       prev_en;
    logic [2:0] prev_addr;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_en = 1'b0;
            prev_addr = '0;
        end else begin
            if (bus.addr != prev_addr) begin
                checks++;
                if (prev_en && bus.en) begin
                    errors++;
                    $display("FAIL addr_change: addr %0d->%0d with en high", prev_addr, bus.addr);
                end
            end
            prev_en = bus.en;
            prev_addr = bus.addr;
        end
    end

    vec_t vecs[5];

    initial begin
        vecs[0] = '{dwell: 8'd3,   poke: 1'b0, exp_done: 48,   exp_en: 40};
        vecs[1] = '{dwell: 8'd0,   poke: 1'b1, exp_done: 32,   exp_en: 24};
        vecs[2] = '{dwell: 8'd1,   poke: 1'b0, exp_done: 32,   exp_en: 24};
        vecs[3] = '{dwell: 8'd5,   poke: 1'b0, exp_done: 64,   exp_en: 56};
        vecs[4] = '{dwell: 8'd255, poke: 1'b0, exp_done: 2064, exp_en: 2056};

        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.stop = 1'b0;
        bus.continuous = 1'b0;
        bus.dwell = '0;
`ifdef BL_SCAN_MASK_EN
        bus.col_mask = '1;
`endif
        cyc = 0;
        repeat (3) @(negedge clk);
        check_obs("reset_state", observe(), '0);
        rst_n = 1'b1;

        foreach (vecs[v]) begin
            build_expect(vecs[v].dwell, 8'hFF, 1'b1);
            kick(vecs[v].dwell, 1'b0, 8'hFF);
            if (vecs[v].poke) begin
                run_queue(10);
                bus.dwell = 8'd7;
                bus.start = 1'b1;
                @(posedge clk);
                #1;
                bus.start = 1'b0;
            end
            run_queue(sb.size());
            check_int("done_cycle", done_at, vecs[v].exp_done);
            check_int("en_cycles", en_count, vecs[v].exp_en);
        end

        // Continuous: restart at column 0 right after Done, then Stop on column 5.
        build_expect(3, 8'hFF, 1'b0);
        build_expect(3, 8'hFF, 1'b0);
        kick(8'd3, 1'b1, 8'hFF);
        run_queue(48 + 5 * 6 + 1);
        check_obs("cont_col5", observe(), mk(1'b1, 5, 1'b0, 1'b1, 1'b0));
        bus.stop = 1'b1;
        @(posedge clk);
        #1;
        bus.stop = 1'b0;
        sb.delete();
        repeat (4) sb.push_back('0);
        run_queue(4);

        // Stop and Start together in IDLE: Start is dropped.
        @(negedge clk);
        bus.start = 1'b1;
        bus.stop = 1'b1;
        bus.dwell = 8'd2;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.stop = 1'b0;
        repeat (3) sb.push_back('0);
        run_queue(3);

        // Asynchronous reset mid-DWELL of column 3 (cycle 21).
        build_expect(3, 8'hFF, 1'b1);
        kick(8'd3, 1'b0, 8'hFF);
        run_queue(21);
        check_int("pre_reset_addr", int'(bus.addr), 3);
        #2;
        rst_n = 1'b0;
        #1;
        check_obs("async_reset", observe(), '0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        sb.delete();
        repeat (2) sb.push_back('0);
        run_queue(2);

`ifdef BL_SCAN_MASK_EN
        build_expect(1, 8'b1000_0101, 1'b1);
        kick(8'd1, 1'b0, 8'b1000_0101);
        run_queue(sb.size());
        check_int("mask_done_cycle", done_at, 12);
        check_int("mask_en_cycles", en_count, 9);

        build_expect(4, 8'h00, 1'b1);
        kick(8'd4, 1'b1, 8'h00);
        run_queue(sb.size() + 2);
        check_int("empty_done_cycle", done_at, 1);
        check_int("empty_en_cycles", en_count, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
